// File: rtl/entropy_packer.sv
// entropy_packer
//   Packs the TRNG bit stream into WORD_W-bit words after the health test,
//   drops any word touched by a health-test error, and buffers clean words
//   in a FIFO read through a valid/ready handshake.
//
//   Optional feature macro: ENTROPY_PACKER_VN_EN (von Neumann debiaser).
//
//   Ports:
//     clk, rst_ni        clock, async active-low reset
//     enable             sampling enable (shared with the health test)
//     rnd_bit            raw entropy bit
//     ht_error           health-test error verdict for this cycle's bit
//     ht_total_failure   health-test total failure; latches alarm
//     rdata / rvalid     head-of-FIFO word (0 when not valid)
//     rready             consumer accepts the head word
//     fifo_level         FIFO occupancy
//     drop_cnt           discarded-word count, saturating
//     alarm              sticky total-failure flag
module entropy_packer #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_ni,
    input  logic                            enable,
    input  logic                            rnd_bit,
    input  logic                            ht_error,
    input  logic                            ht_total_failure,
    output logic [WORD_W-1:0]               rdata,
    output logic                            rvalid,
    input  logic                            rready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic [15:0]                     drop_cnt,
    output logic                            alarm
);
    localparam int CNT_W = $clog2(WORD_W);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = $clog2(FIFO_DEPTH+1);

    // Only WORD_W-1 bits need storing; the completing bit joins them on the fly.
    logic [WORD_W-2:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              taint_q, taint_d;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [15:0]       drop_q, drop_d;
    logic              alarm_q, alarm_d;
`ifdef ENTROPY_PACKER_VN_EN
    logic              pair_have_q, pair_have_d;
    logic              pair_bit_q, pair_bit_d;
`endif

    logic              accept, kill, good, gbit, complete, tainted;
    logic              can_push, push, pop, drop;
    logic [WORD_W-1:0] word_next;

    assign rvalid     = (level_q != '0) && !alarm_q;
    assign rdata      = rvalid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign drop_cnt   = drop_q;
    assign alarm      = alarm_q;

    always_comb begin
        accept = enable && !alarm_q;
        // A total failure flushes everything on the same edge that sets alarm.
        kill   = alarm_q || ht_total_failure;

`ifdef ENTROPY_PACKER_VN_EN
        pair_have_d = pair_have_q;
        pair_bit_d  = pair_bit_q;
        good        = 1'b0;
        gbit        = pair_bit_q;
        if (accept) begin
            if (!pair_have_q) begin
                pair_have_d = 1'b1;
                pair_bit_d  = rnd_bit;
            end else begin
                // Word completion can only happen here, so pairs never split.
                pair_have_d = 1'b0;
                good        = pair_bit_q ^ rnd_bit;
            end
        end
`else
        good = accept;
        gbit = rnd_bit;
`endif

        word_next = {word_q, gbit};
        complete  = good && (cnt_q == CNT_W'(WORD_W-1));
        tainted   = taint_q || (accept && ht_error);
        pop       = rvalid && rready && !kill;
        can_push  = (level_q < LW'(FIFO_DEPTH)) || pop;
        push      = complete && !tainted && can_push && !kill;
        // Tainted and full together still count once.
        drop      = complete && !(!tainted && can_push) && !kill;

        word_d   = word_q;
        cnt_d    = cnt_q;
        taint_d  = taint_q;
        if (good) begin
            word_d = word_next[WORD_W-2:0];
            cnt_d  = complete ? '0 : cnt_q + CNT_W'(1);
        end
        if (complete)                taint_d = 1'b0;
        else if (accept && ht_error) taint_d = 1'b1;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = word_next;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);

        drop_d  = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        alarm_d = alarm_q || ht_total_failure;

        if (kill) begin
            word_d   = '0;
            cnt_d    = '0;
            taint_d  = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
`ifdef ENTROPY_PACKER_VN_EN
            pair_have_d = 1'b0;
            pair_bit_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q   <= '0;
            cnt_q    <= '0;
            taint_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            alarm_q  <= 1'b0;
`ifdef ENTROPY_PACKER_VN_EN
            pair_have_q <= 1'b0;
            pair_bit_q  <= 1'b0;
`endif
        end else begin
            word_q   <= word_d;
            cnt_q    <= cnt_d;
            taint_q  <= taint_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            alarm_q  <= alarm_d;
`ifdef ENTROPY_PACKER_VN_EN
            pair_have_q <= pair_have_d;
            pair_bit_q  <= pair_bit_d;
`endif
        end
    end
endmodule

// File: tb/tb_entropy_packer.sv
// Directed bench for entropy_packer at WORD_W=8, FIFO_DEPTH=4. Words are fed
// as "good" bits; with ENTROPY_PACKER_VN_EN each good bit is sent as a
// differing raw pair so the same expectations hold in both builds.
module tb_entropy_packer;
    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       enable = 1'b0, rnd_bit = 1'b0, ht_error = 1'b0, ht_total_failure = 1'b0;
    logic       rready = 1'b0;
    logic [7:0] rdata;
    logic       rvalid, alarm;
    logic [2:0] fifo_level;
    logic [15:0] drop_cnt;

    int n_chk = 0, n_pass = 0;

    entropy_packer #(.WORD_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_ni(rst_ni), .enable(enable), .rnd_bit(rnd_bit),
        .ht_error(ht_error), .ht_total_failure(ht_total_failure),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt), .alarm(alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         err_at;    // stream position 0..7 carrying ht_error, 8 = none
        int         exp_level;
        int         exp_drop;
        logic [7:0] exp_head;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic raw(input logic b, input logic err, input logic rr);
        enable = 1'b1; rnd_bit = b; ht_error = err; rready = rr;
        tick();
        enable = 1'b0; ht_error = 1'b0; rready = 1'b0;
    endtask

    task automatic send_good(input logic b, input logic err, input logic rr);
`ifdef ENTROPY_PACKER_VN_EN
        raw(b, 1'b0, 1'b0);
        raw(~b, err, rr);
`else
        raw(b, err, rr);
`endif
    endtask

    task automatic send_word(input logic [7:0] d, input int err_at);
        for (int k = 0; k < 8; k++) send_good(d[7-k], k == err_at, 1'b0);
    endtask

    // Enable low with noisy inputs: nothing may be accepted or tainted.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            rnd_bit = 1'($urandom); ht_error = 1'b1;
            tick();
        end
        ht_error = 1'b0;
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk(name, {63'd0, rvalid}, 64'd1);
        chk(name, {56'd0, rdata}, {56'd0, exp});
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick(); tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        int ones;
        logic [19:0] vn_seq;
        logic [7:0]  pt_seq;

        tbl[0] = '{8'hB2, 8, 1, 0, 8'hB2};
        tbl[1] = '{8'h5A, 4, 1, 1, 8'hB2};   // error mid-word
        tbl[2] = '{8'hFF, 8, 2, 1, 8'hB2};
        tbl[3] = '{8'h00, 7, 2, 2, 8'hB2};   // error on completing bit
        tbl[4] = '{8'h01, 8, 3, 2, 8'hB2};
        tbl[5] = '{8'h02, 8, 4, 2, 8'hB2};
        tbl[6] = '{8'h03, 8, 4, 3, 8'hB2};   // FIFO full

        // Reset state
        tick();
        chk("rst_rdata",  {56'd0, rdata}, 64'd0);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_level",  {61'd0, fifo_level}, 64'd0);
        chk("rst_drop",   {48'd0, drop_cnt}, 64'd0);
        chk("rst_alarm",  {63'd0, alarm}, 64'd0);
        rst_ni = 1'b1;
        tick();

        // Raw-stream vector for the active build
`ifdef ENTROPY_PACKER_VN_EN
        vn_seq = 20'b10_01_11_10_01_00_01_10_01_10;
        for (int k = 19; k >= 0; k--) raw(vn_seq[k], 1'b0, 1'b0);
        chk("vn_rdata", {56'd0, rdata}, 64'hA5);
`else
        pt_seq = 8'b1011_0010;
        for (int k = 7; k >= 1; k--) raw(pt_seq[k], 1'b0, 1'b0);
        chk("pt_early_rvalid", {63'd0, rvalid}, 64'd0);
        raw(pt_seq[0], 1'b0, 1'b0);
        chk("pt_rdata", {56'd0, rdata}, 64'hB2);
`endif
        chk("raw_rvalid", {63'd0, rvalid}, 64'd1);
        chk("raw_level",  {61'd0, fifo_level}, 64'd1);
        chk("raw_drop",   {48'd0, drop_cnt}, 64'd0);
        do_reset();

        // Table: taint, full FIFO, drop counting
        for (int i = 0; i < 7; i++) begin
            send_word(tbl[i].data, tbl[i].err_at);
            chk($sformatf("tbl%0d_level", i), {61'd0, fifo_level}, 64'(tbl[i].exp_level));
            chk($sformatf("tbl%0d_drop", i),  {48'd0, drop_cnt}, 64'(tbl[i].exp_drop));
            chk($sformatf("tbl%0d_head", i),  {56'd0, rdata}, {56'd0, tbl[i].exp_head});
        end
        pop_chk("tbl_pop0", 8'hB2);
        pop_chk("tbl_pop1", 8'hFF);
        pop_chk("tbl_pop2", 8'h01);
        pop_chk("tbl_pop3", 8'h02);
        chk("empty_rvalid", {63'd0, rvalid}, 64'd0);
        chk("empty_rdata",  {56'd0, rdata}, 64'd0);
        chk("empty_level",  {61'd0, fifo_level}, 64'd0);

        // Push and pop on the same edge while full
        for (int w = 0; w < 4; w++) send_word(8'h11 + 8'(w), 8);
        chk("pp_full", {61'd0, fifo_level}, 64'd4);
        for (int k = 7; k >= 1; k--) send_good(1'((8'h15 >> k) & 8'h1), 1'b0, 1'b0);
        send_good(1'b1, 1'b0, 1'b1);
        chk("pp_level", {61'd0, fifo_level}, 64'd4);
        chk("pp_drop",  {48'd0, drop_cnt}, 64'd3);
        pop_chk("pp_pop0", 8'h12);
        pop_chk("pp_pop1", 8'h13);
        pop_chk("pp_pop2", 8'h14);
        pop_chk("pp_pop3", 8'h15);

        // Reset mid-word, with enable-low noise that must be ignored
        do_reset();
        for (int k = 0; k < 5; k++) send_good(1'b1, 1'b0, 1'b0);
        do_reset();
        for (int k = 7; k >= 4; k--) send_good(1'((8'h3C >> k) & 8'h1), 1'b0, 1'b0);
        idle(3);
        for (int k = 3; k >= 0; k--) send_good(1'((8'h3C >> k) & 8'h1), 1'b0, 1'b0);
        chk("mid_level", {61'd0, fifo_level}, 64'd1);
        chk("mid_rdata", {56'd0, rdata}, 64'h3C);
        chk("mid_drop",  {48'd0, drop_cnt}, 64'd0);

        // Alarm
        do_reset();
        send_word(8'hC3, 8);
        send_word(8'h81, 8);
        chk("al_pre_level", {61'd0, fifo_level}, 64'd2);
        ht_total_failure = 1'b1; rready = 1'b1;
        tick();
        ht_total_failure = 1'b0; rready = 1'b0;
        chk("al_alarm",  {63'd0, alarm}, 64'd1);
        chk("al_rvalid", {63'd0, rvalid}, 64'd0);
        chk("al_rdata",  {56'd0, rdata}, 64'd0);
        tick();
        chk("al_level",  {61'd0, fifo_level}, 64'd0);
        ones = 0;
        for (int k = 0; k < 100; k++) begin
            raw(1'($urandom), 1'($urandom), 1'b1);
            if (rvalid) ones++;
        end
        chk("al_quiet",  64'(ones), 64'd0);
        chk("al_level2", {61'd0, fifo_level}, 64'd0);
        chk("al_drop",   {48'd0, drop_cnt}, 64'd0);
        chk("al_sticky", {63'd0, alarm}, 64'd1);
        do_reset();
        chk("al_clear",  {63'd0, alarm}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
